flash_cache_controller: RTL and testbench



---
 rtl/flash_cache_controller.sv | 138 +++++++++++++
 tb/tb_flash_cache_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/flash_cache_controller.sv
// Read-only direct-mapped flash cache: combinational hits, whole-line fills from the QSPI side.
// Optional hit/miss counters are built when FLASH_CACHE_STATS_EN is defined.
module flash_cache_controller #(
  parameter int unsigned LINE_WORDS    = 4,
  parameter int unsigned LINES         = 8,
  parameter int unsigned ADDRESS_WIDTH = 24
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     flashCache_readEnable,
  input  logic [ADDRESS_WIDTH-1:0] flashCache_address,
  input  logic [3:0]               flashCache_byteSelect,
  output logic [31:0]              flashCache_dataRead,
  output logic                     flashCache_busy,
  input  logic                     cache_flush,
  output logic                     flash_request,
  output logic [ADDRESS_WIDTH-1:0] flash_address,
  input  logic                     flash_dataValid,
  input  logic [31:0]              flash_data,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count
);

  localparam int unsigned OffW = $clog2(LINE_WORDS);
  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned LoW  = OffW + 2;
  localparam int unsigned TagW = ADDRESS_WIDTH - LoW - IdxW;

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e                   state_q;
  logic [LINES-1:0]         valid_q;
  logic [TagW-1:0]          tag_q  [LINES];
  logic [31:0]              data_q [LINES][LINE_WORDS];
  logic                     flash_request_q;
  logic [ADDRESS_WIDTH-1:0] flash_address_q;
  logic [OffW-1:0]          cnt_q;
  logic                     abort_q;

  logic [OffW-1:0] req_off;
  logic [IdxW-1:0] req_idx;
  logic [TagW-1:0] req_tag;
  logic [IdxW-1:0] fill_idx;
  logic [TagW-1:0] fill_tag;
  logic            hit;
  logic            last_word;
  logic            unused_ok;

  assign req_off   = flashCache_address[LoW-1:2];
  assign req_idx   = flashCache_address[LoW+IdxW-1:LoW];
  assign req_tag   = flashCache_address[ADDRESS_WIDTH-1:LoW+IdxW];
  assign fill_idx  = flash_address_q[LoW+IdxW-1:LoW];
  assign fill_tag  = flash_address_q[ADDRESS_WIDTH-1:LoW+IdxW];
  assign unused_ok = ^{flashCache_byteSelect, flashCache_address[1:0], flash_address_q[LoW-1:0]};

  assign hit       = flashCache_readEnable && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign last_word = (state_q == StFill) && flash_dataValid && (cnt_q == OffW'(LINE_WORDS - 1));

  assign flashCache_busy     = flashCache_readEnable && ((state_q != StIdle) || !hit);
  assign flashCache_dataRead = hit ? data_q[req_idx][req_off] : 32'hFFFF_FFFF;
  assign flash_request       = flash_request_q;
  assign flash_address       = flash_address_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q         <= StIdle;
      valid_q         <= '0;
      flash_request_q <= 1'b0;
      flash_address_q <= '0;
      cnt_q           <= '0;
      abort_q         <= 1'b0;
      for (int i = 0; i < int'(LINES); i++) tag_q[i] <= '0;
    end else begin
      if (cache_flush) valid_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (flashCache_readEnable && !hit) begin
            flash_address_q  <= {flashCache_address[ADDRESS_WIDTH-1:LoW], {LoW{1'b0}}};
            cnt_q            <= '0;
            abort_q          <= 1'b0;
            // Victim is invalidated up front so a partially filled line can never hit.
            valid_q[req_idx] <= 1'b0;
            flash_request_q  <= 1'b1;
            state_q          <= StFill;
          end
        end
        StFill: begin
          if (cache_flush) abort_q <= 1'b1;
          if (flash_dataValid) cnt_q <= cnt_q + 1'b1;
          if (last_word) begin
            flash_request_q   <= 1'b0;
            tag_q[fill_idx]   <= fill_tag;
            valid_q[fill_idx] <= !(abort_q || cache_flush);
            state_q           <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Line storage needs no reset: valid bits gate every use of it.
  always_ff @(posedge wb_clk_i) begin
    if ((state_q == StFill) && flash_dataValid) data_q[fill_idx][cnt_q] <= flash_data;
  end

`ifdef FLASH_CACHE_STATS_EN
  logic [15:0] hit_count_q;
  logic [15:0] miss_count_q;
  logic        pending_q;

  // pending_q marks a read that already missed, so its eventual hit is not counted.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      pending_q    <= 1'b0;
    end else if (state_q == StIdle) begin
      if (!flashCache_readEnable) begin
        pending_q <= 1'b0;
      end else if (!hit) begin
        pending_q <= 1'b1;
        if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
      end else begin
        pending_q <= 1'b0;
        if (!pending_q && (hit_count_q != 16'hFFFF)) hit_count_q <= hit_count_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = 16'd0;
  assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_flash_cache_controller.sv
// Scoreboard bench for flash_cache_controller: directed reads, a scripted flash model,
// and a monitor that checks read data whenever the cache presents a serviced read.
module tb_flash_cache_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re;
  logic [23:0] addr;
  logic [3:0]  be;
  logic [31:0] dread;
  logic        busy;
  logic        flush;
  logic        freq;
  logic [23:0] faddr;
  logic        fvalid;
  logic [31:0] fdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_rd[$];
  logic [23:0] exp_fill[$];
  logic [31:0] fm_words[$];
  int          fm_idx = 0;

  always #5 clk = ~clk;

  flash_cache_controller dut (
    .wb_clk_i              (clk),
    .wb_rst_ni             (rst_n),
    .flashCache_readEnable (re),
    .flashCache_address    (addr),
    .flashCache_byteSelect (be),
    .flashCache_dataRead   (dread),
    .flashCache_busy       (busy),
    .cache_flush           (flush),
    .flash_request         (freq),
    .flash_address         (faddr),
    .flash_dataValid       (fvalid),
    .flash_data            (fdata),
    .hit_count             (hit_cnt),
    .miss_count            (miss_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Flash model: streams scripted words on consecutive cycles while a fill is requested.
  initial begin
    fvalid = 1'b0;
    fdata  = '0;
    forever begin
      @(negedge clk);
      if (!freq) begin
        fm_idx = 0;
        fvalid = 1'b0;
      end else if (fm_words.size() > 0) begin
        if (fm_idx == 0) begin
          if (exp_fill.size() == 0) begin
            total++;
            bad++;
            $display("FAIL fill_unexpected: got %h, want no fill", faddr);
          end else begin
            check("fill_addr", {8'h0, faddr}, {8'h0, exp_fill.pop_front()});
          end
        end
        fvalid = 1'b1;
        fdata  = fm_words.pop_front();
        fm_idx++;
      end else begin
        fvalid = 1'b0;
      end
    end
  end

  // Read monitor: every serviced read must match the next expected word.
  always @(negedge clk) begin
    if (rst_n && re && !busy) begin
      if (exp_rd.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got %h, want no read", dread);
      end else begin
        check("rd_data", dread, exp_rd.pop_front());
      end
    end
  end

  task automatic push_fill(input logic [23:0] a, input logic [31:0] base);
    exp_fill.push_back(a);
    for (int i = 0; i < 4; i++) fm_words.push_back(base + 32'(i));
  endtask

  // Holds a read until serviced; lat is the expected number of busy cycles.
  task automatic do_read(input logic [23:0] a, input logic [31:0] d, input int lat);
    int n = 0;
    exp_rd.push_back(d);
    @(posedge clk);
    #1;
    re   = 1'b1;
    addr = a;
    be   = 4'hF;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL rd_timeout: got busy at %h, want serviced", a);
    end else begin
      check("latency", 32'(n), 32'(lat));
      if (lat == 0) check("req_on_hit", {31'd0, freq}, 32'd0);
    end
    @(posedge clk);
    #1;
    re = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    re    = 1'b0;
    addr  = '0;
    be    = '0;
    flush = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dread", dread, 32'hFFFF_FFFF);
    check("rst_req", {31'd0, freq}, 32'd0);
    check("rst_faddr", {8'h0, faddr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    push_fill(24'h000100, 32'hA0);
    do_read(24'h000104, 32'hA1, 5);
    do_read(24'h00010C, 32'hA3, 0);
    push_fill(24'h000180, 32'hB0);
    do_read(24'h000184, 32'hB1, 5);
    push_fill(24'h000100, 32'hA0);
    do_read(24'h000104, 32'hA1, 5);

    // Flush on the third fill word: first fill discarded, second fill serves the read.
    push_fill(24'h000200, 32'hC0);
    push_fill(24'h000200, 32'hD0);
    fork
      do_read(24'h000200, 32'hD0, 10);
      begin
        for (int k = 0; k < 50 && fm_idx != 3; k++) begin
          @(negedge clk);
          #1;
        end
        check("flush_sync", 32'(fm_idx), 32'd3);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
      end
    join
    do_read(24'h000208, 32'hD2, 0);

    push_fill(24'hFFFFF0, 32'hE0);
    do_read(24'hFFFFFC, 32'hE3, 5);
    do_read(24'hFFFFF0, 32'hE0, 0);
    push_fill(24'h000010, 32'hF0);
    do_read(24'h000014, 32'hF1, 5);

    // Reset after two fill words of a miss.
    exp_fill.push_back(24'h000300);
    fm_words.push_back(32'h60);
    fm_words.push_back(32'h61);
    @(posedge clk);
    #1;
    re   = 1'b1;
    addr = 24'h000300;
    for (int k = 0; k < 50 && fm_idx != 2; k++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    re    = 1'b0;
    #1;
    check("rst_mid_req", {31'd0, freq}, 32'd0);
    check("rst_mid_faddr", {8'h0, faddr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    push_fill(24'h000010, 32'h70);
    do_read(24'h000010, 32'h70, 5);
    do_read(24'h000014, 32'h71, 0);
    do_read(24'h000018, 32'h72, 0);
    do_read(24'h00001C, 32'h73, 0);
`ifdef FLASH_CACHE_STATS_EN
    check("miss_count", {16'h0, miss_cnt}, 32'd1);
    check("hit_count", {16'h0, hit_cnt}, 32'd3);
`else
    check("miss_count", {16'h0, miss_cnt}, 32'd0);
    check("hit_count", {16'h0, hit_cnt}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    check("rd_left", 32'(exp_rd.size()), 32'd0);
    check("fill_left", 32'(exp_fill.size()), 32'd0);
    check("words_left", 32'(fm_words.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
